// File: rtl/camera_scroll.sv
`timescale 1ns/1ps
// Per-frame camera stage: snapshots Mario, advances a right-only scroll offset
// and emits screen-relative sprite coordinates. Optional macro: CAMERA_SMOOTH_EN.
module camera_scroll #(
    parameter logic [10:0] PUSH_X      = 11'd480,
    parameter logic [10:0] MAX_VIEW_X  = 11'd1024,
    parameter logic [10:0] SCROLL_STEP = 11'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [10:0] mario_x,
    input  logic [9:0]  mario_y,
    input  logic [5:0]  mario_id,
    output logic [10:0] view_x,
    output logic [10:0] mario_sx,
    output logic [9:0]  mario_sy,
    output logic [5:0]  mario_sid,
    output logic        left_block,
    output logic        snap_valid
);

    localparam int unsigned XW  = 11;
    localparam int unsigned YW  = 10;
    localparam int unsigned IDW = 6;
    localparam int unsigned SW  = 12;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   snap_x_q, snap_x_d;
    logic [YW-1:0]   snap_y_q, snap_y_d;
    logic [IDW-1:0]  snap_id_q, snap_id_d;
    logic [XW-1:0]   step_q, step_d;
    logic [XW-1:0]   view_x_q, view_x_d;
    logic [XW-1:0]   mario_sx_q, mario_sx_d;
    logic [YW-1:0]   mario_sy_q, mario_sy_d;
    logic [IDW-1:0]  mario_sid_q, mario_sid_d;
    logic            left_block_q, left_block_d;
    logic            snap_valid_q, snap_valid_d;

    logic [SW-1:0]   push_lim, target, step_w, new_view, snap_x_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_id_q    <= '0;
            step_q       <= '0;
            view_x_q     <= '0;
            mario_sx_q   <= '0;
            mario_sy_q   <= '0;
            mario_sid_q  <= IDW'(32);
            left_block_q <= 1'b0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_id_q    <= snap_id_d;
            step_q       <= step_d;
            view_x_q     <= view_x_d;
            mario_sx_q   <= mario_sx_d;
            mario_sy_q   <= mario_sy_d;
            mario_sid_q  <= mario_sid_d;
            left_block_q <= left_block_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    // Next-state and datapath; all sums are 12 bits so nothing wraps near 2047
    always_comb begin
        state_d      = state_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_id_d    = snap_id_q;
        step_d       = step_q;
        view_x_d     = view_x_q;
        mario_sx_d   = mario_sx_q;
        mario_sy_d   = mario_sy_q;
        mario_sid_d  = mario_sid_q;
        left_block_d = left_block_q;
        snap_valid_d = 1'b0;

        snap_x_w = {1'b0, snap_x_q};
        push_lim = {1'b0, view_x_q} + {1'b0, PUSH_X};
        target   = (snap_x_w > push_lim) ? (snap_x_w - {1'b0, PUSH_X}) : {1'b0, view_x_q};
        if (target > {1'b0, MAX_VIEW_X}) begin
            target = {1'b0, MAX_VIEW_X};
        end
        // target never falls below view_x, so the step cannot go negative
        step_w = target - {1'b0, view_x_q};
`ifdef CAMERA_SMOOTH_EN
        if (step_w > {1'b0, SCROLL_STEP}) begin
            step_w = {1'b0, SCROLL_STEP};
        end
`endif
        new_view = {1'b0, view_x_q} + {1'b0, step_q};

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    snap_x_d  = mario_x;
                    snap_y_d  = mario_y;
                    snap_id_d = mario_id;
                    state_d   = CALC;
                end
            end
            CALC: begin
                step_d  = XW'(step_w);
                state_d = COMMIT;
            end
            COMMIT: begin
                view_x_d     = XW'(new_view);
                mario_sx_d   = (snap_x_w >= new_view) ? XW'(snap_x_w - new_view) : '0;
                left_block_d = (snap_x_w <= new_view);
                mario_sy_d   = snap_y_q;
                mario_sid_d  = snap_id_q;
                snap_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign view_x     = view_x_q;
    assign mario_sx   = mario_sx_q;
    assign mario_sy   = mario_sy_q;
    assign mario_sid  = mario_sid_q;
    assign left_block = left_block_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_camera_scroll.sv
`timescale 1ns/1ps
// Directed bench for camera_scroll: frame vector table plus reset and
// re-triggered frame_tick sequences.
module tb_camera_scroll;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [10:0] mario_x;
    logic [9:0]  mario_y;
    logic [5:0]  mario_id;
    logic [10:0] view_x;
    logic [10:0] mario_sx;
    logic [9:0]  mario_sy;
    logic [5:0]  mario_sid;
    logic        left_block;
    logic        snap_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    camera_scroll dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .mario_x    (mario_x),
        .mario_y    (mario_y),
        .mario_id   (mario_id),
        .view_x     (view_x),
        .mario_sx   (mario_sx),
        .mario_sy   (mario_sy),
        .mario_sid  (mario_sid),
        .left_block (left_block),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int id;
        int e_view; int e_sx; int e_lb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: tick sampled at edge N; checks pulse timing and outputs at N+2
    task automatic run_frame(input int x, input int y, input int id,
                             input int e_view, input int e_sx, input int e_lb,
                             input string tag);
        @(negedge clk);
        mario_x    = 11'(x);
        mario_y    = 10'(y);
        mario_id   = 6'(id);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk({tag, " valid@N"}, int'(snap_valid), 0);
        @(negedge clk);
        chk({tag, " valid@N+1"}, int'(snap_valid), 0);
        @(negedge clk);
        chk({tag, " valid@N+2"}, int'(snap_valid), 1);
        chk({tag, " view_x"}, int'(view_x), e_view);
        chk({tag, " mario_sx"}, int'(mario_sx), e_sx);
        chk({tag, " mario_sy"}, int'(mario_sy), y);
        chk({tag, " mario_sid"}, int'(mario_sid), id);
        chk({tag, " left_block"}, int'(left_block), e_lb);
        @(negedge clk);
        chk({tag, " valid@N+3"}, int'(snap_valid), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " view_x"}, int'(view_x), 0);
        chk({tag, " mario_sx"}, int'(mario_sx), 0);
        chk({tag, " mario_sy"}, int'(mario_sy), 0);
        chk({tag, " mario_sid"}, int'(mario_sid), 32);
        chk({tag, " left_block"}, int'(left_block), 0);
        chk({tag, " snap_valid"}, int'(snap_valid), 0);
    endtask

    initial begin
        int pulses;

`ifdef CAMERA_SMOOTH_EN
        vecs.push_back('{128, 704, 32, 0, 128, 0});
        for (int k = 1; k <= 16; k++) begin
            int v;
            v = (8 * k > 120) ? 120 : 8 * k;
            vecs.push_back('{600, 704, 33, v, 600 - v, 0});
        end
        vecs.push_back('{100, 700, 34, 120, 0, 1});
        vecs.push_back('{200, 700, 35, 120, 80, 0});
`else
        vecs.push_back('{128,  704, 32, 0,    128,  0});
        vecs.push_back('{600,  704, 33, 120,  480,  0});
        vecs.push_back('{600,  704, 33, 120,  480,  0});
        vecs.push_back('{100,  700, 34, 120,  0,    1});
        vecs.push_back('{200,  700, 35, 120,  80,   0});
        vecs.push_back('{120,  512, 36, 120,  0,    1});
        vecs.push_back('{1900, 100, 37, 1024, 876,  0});
        vecs.push_back('{2000, 100, 38, 1024, 976,  0});
        vecs.push_back('{2047, 1023, 63, 1024, 1023, 0});
        vecs.push_back('{500,  0,   0,  1024, 0,    1});
`endif

        rst        = 1'b0;
        frame_tick = 1'b0;
        mario_x    = '0;
        mario_y    = '0;
        mario_id   = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_frame(vecs[i].x, vecs[i].y, vecs[i].id,
                      vecs[i].e_view, vecs[i].e_sx, vecs[i].e_lb,
                      $sformatf("vec%0d", i));
        end

        // Reset asserted while the FSM is in CALC
        @(negedge clk);
        mario_x    = 11'd1500;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rst        = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (snap_valid) pulses++;
        end
        chk("post-rst idle pulses", pulses, 0);
        chk("post-rst view_x", int'(view_x), 0);

        run_frame(128, 704, 32, 0, 128, 0, "after_rst");

        // Second tick during CALC must be dropped
        @(negedge clk);
        mario_x    = 11'd300;
        mario_y    = 10'd50;
        mario_id   = 6'd40;
        frame_tick = 1'b1;
        @(negedge clk);
        mario_x    = 11'd900;
        mario_y    = 10'd60;
        mario_id   = 6'd41;
        @(negedge clk);
        frame_tick = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (snap_valid) pulses++;
        end
        chk("retick pulses", pulses, 1);
        chk("retick view_x", int'(view_x), 0);
        chk("retick mario_sx", int'(mario_sx), 300);
        chk("retick mario_sy", int'(mario_sy), 50);
        chk("retick mario_sid", int'(mario_sid), 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
